// File: rtl/pos_cell_pingpong.sv
// pos_cell_pingpong
// Double-buffered per-cell position memory. Force evaluation reads the active
// bank while motion update appends into the shadow bank. A swap pulse
// exchanges the banks at the timestep boundary.
//
// Ports
//   clock         rising-edge clock
//   rst_n         asynchronous active-low reset
//   rd_en         read request against the active bank
//   rd_addr       0 = particle count, 1..count = particles, above count = zero
//   rd_data       read result, valid two edges after the request is sampled
//   rd_valid      qualifies rd_data
//   wr_en         append wr_data to the shadow bank
//   wr_data       particle word {posz, posy, posx}
//   swap          single-cycle pulse exchanging active and shadow banks
//   active_count  particle count of the active bank
//   shadow_count  particle count of the shadow bank
//   bank_sel      index of the active bank
//   overflow      sticky: an append was dropped because the shadow bank was full
`timescale 1ns/1ps
module pos_cell_pingpong #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  swap,
  output logic [ADDR_WIDTH-1:0] active_count,
  output logic [ADDR_WIDTH-1:0] shadow_count,
  output logic                  bank_sel,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);

  logic [DATA_WIDTH-1:0] bank0_mem [PARTICLE_NUM];
  logic [DATA_WIDTH-1:0] bank1_mem [PARTICLE_NUM];

  logic                  bank_sel_q;
  logic [ADDR_WIDTH-1:0] active_count_q;
  logic [ADDR_WIDTH-1:0] shadow_count_q;
  logic [ADDR_WIDTH-1:0] shadow_count_d;
  logic                  overflow_q;

  logic                  s1_valid_q;
  logic                  s1_zero_q;
  logic                  s1_hit_q;
  logic [ADDR_WIDTH-1:0] s1_count_q;
  logic [DATA_WIDTH-1:0] ram_rd_q;

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  shadow_full;
  logic                  wr_accept;
  logic                  wr_drop;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_hit;

  assign shadow_full = (shadow_count_q == LAST_ADDR);
  assign wr_accept   = wr_en && !shadow_full;
  assign wr_drop     = wr_en && shadow_full;
  assign wr_addr     = shadow_count_q + ADDR_WIDTH'(1);
  // Includes an append accepted in the same cycle, so a swap carries it over.
  assign shadow_count_d = wr_accept ? wr_addr : shadow_count_q;
  // Only in-range addresses touch the RAM; this also keeps the index inside
  // the array since the count never exceeds LAST_ADDR.
  assign rd_hit = (rd_addr != '0) && (rd_addr <= active_count_q);

  // RAM arrays: no reset, contents unreachable until rewritten.
  // The shadow bank is the one not selected by bank_sel_q.
  always_ff @(posedge clock) begin
    if (wr_accept && bank_sel_q)  bank0_mem[wr_addr] <= wr_data;
    if (wr_accept && !bank_sel_q) bank1_mem[wr_addr] <= wr_data;
    if (rd_en && rd_hit)
      ram_rd_q <= bank_sel_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q     <= 1'b0;
      active_count_q <= '0;
      shadow_count_q <= '0;
      overflow_q     <= 1'b0;
    end else if (swap) begin
      bank_sel_q     <= ~bank_sel_q;
      active_count_q <= shadow_count_d;
      shadow_count_q <= '0;
      overflow_q     <= wr_drop;
    end else begin
      shadow_count_q <= shadow_count_d;
      overflow_q     <= overflow_q | wr_drop;
    end
  end

  // Read pipeline: address class and count are captured with the request so
  // a swap in the issue cycle cannot change the answer.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_count_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) begin
        s1_zero_q  <= (rd_addr == '0);
        s1_hit_q   <= rd_hit;
        s1_count_q <= active_count_q;
      end
      rd_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        if (s1_zero_q)
          rd_data_q <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, s1_count_q};
        else if (s1_hit_q)
          rd_data_q <= ram_rd_q;
        else
          rd_data_q <= '0;
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign active_count = active_count_q;
  assign shadow_count = shadow_count_q;
  assign bank_sel     = bank_sel_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pos_cell_pingpong.sv
`timescale 1ns/1ps
module tb_pos_cell_pingpong;

  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          swap = 1'b0;
  logic [AW-1:0] active_count;
  logic [AW-1:0] shadow_count;
  logic          bank_sel;
  logic          overflow;

  pos_cell_pingpong #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_data(wr_data), .swap(swap),
    .active_count(active_count), .shadow_count(shadow_count),
    .bank_sel(bank_sel), .overflow(overflow)
  );

  always #5 clock = ~clock;

  localparam logic [DW-1:0] WA  = 96'h0000_00A3_0000_00A2_0000_00A1;
  localparam logic [DW-1:0] WB  = 96'h0000_00B3_0000_00B2_0000_00B1;
  localparam logic [DW-1:0] WC  = 96'h0000_00C3_0000_00C2_0000_00C1;
  localparam logic [DW-1:0] WD  = 96'h0000_00D3_0000_00D2_0000_00D1;
  localparam logic [DW-1:0] WA2 = 96'h1111_00A3_1111_00A2_1111_00A1;
  localparam logic [DW-1:0] WB2 = 96'h1111_00B3_1111_00B2_1111_00B1;

  int tests = 0;
  int fails = 0;

  // expected read pipeline: cur = issued this cycle, q0 = sampled, q1 = due now
  logic          cur_v = 1'b0, q0_v = 1'b0, q1_v = 1'b0;
  logic [DW-1:0] cur_d = '0, q0_d = '0, q1_d = '0;

  function automatic logic [DW-1:0] w(int i);
    return {32'(32'h3000_0000 + i), 32'(32'h2000_0000 + i), 32'(32'h1000_0000 + i)};
  endfunction

  function automatic logic [DW-1:0] x(int i);
    return {32'(32'hAAAA_0000 + i), 32'(32'hBBBB_0000 + i), 32'(32'hCCCC_0000 + i)};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    cur_v   = 1'b1;
    cur_d   = e;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    swap  = 1'b0;
    q1_v = q0_v;  q1_d = q0_d;
    q0_v = cur_v; q0_d = cur_d;
    cur_v = 1'b0;
    chk("rd_valid", DW'(rd_valid), DW'(q1_v));
    if (q1_v) chk("rd_data", rd_data, q1_d);
  endtask

  task automatic flush_model();
    cur_v = 1'b0; q0_v = 1'b0; q1_v = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_bank_sel", DW'(bank_sel), '0);
    chk("rst_active", DW'(active_count), '0);
    chk("rst_shadow", DW'(shadow_count), '0);
    chk("rst_overflow", DW'(overflow), '0);
    chk("rst_rd_valid", DW'(rd_valid), '0);
    chk("rst_rd_data", rd_data, '0);
    rst_n = 1'b1;
    tick();

    // count read after reset
    rd(0, '0); tick(); tick();
    chk("t1_active", DW'(active_count), '0);
    chk("t1_bank_sel", DW'(bank_sel), '0);

    // append A,B,C then swap, read back 0..4
    wr_en = 1'b1; wr_data = WA; tick();
    wr_en = 1'b1; wr_data = WB; tick();
    wr_en = 1'b1; wr_data = WC; tick();
    chk("t2_shadow_pre", DW'(shadow_count), DW'(3));
    chk("t2_active_pre", DW'(active_count), '0);
    swap = 1'b1; tick();
    chk("t2_bank_sel", DW'(bank_sel), DW'(1));
    chk("t2_active", DW'(active_count), DW'(3));
    chk("t2_shadow", DW'(shadow_count), '0);
    rd(0, DW'(3)); tick();
    rd(1, WA); tick();
    rd(2, WB); tick();
    rd(3, WC); tick();
    rd(4, '0); tick();
    tick(); tick();

    // append with swap in the same cycle; read during swap hits old bank
    wr_en = 1'b1; wr_data = WA2; tick();
    wr_en = 1'b1; wr_data = WB2; tick();
    wr_en = 1'b1; wr_data = WD; swap = 1'b1; rd(1, WA); tick();
    chk("t3_active", DW'(active_count), DW'(3));
    chk("t3_bank_sel", DW'(bank_sel), '0);
    chk("t3_shadow", DW'(shadow_count), '0);
    rd(3, WD); tick();
    rd(1, WA2); tick();
    rd(2, WB2); tick();
    rd(4, '0); tick();
    rd(0, DW'(3)); tick();
    tick(); tick();

    // fill to capacity, then one dropped append
    for (int i = 1; i <= PN - 1; i++) begin
      wr_en = 1'b1; wr_data = w(i); tick();
    end
    chk("t4_shadow_full", DW'(shadow_count), DW'(PN - 1));
    chk("t4_ovf_before", DW'(overflow), '0);
    wr_en = 1'b1; wr_data = w(PN); tick();
    chk("t4_shadow_hold", DW'(shadow_count), DW'(PN - 1));
    chk("t4_ovf_set", DW'(overflow), DW'(1));
    tick();
    chk("t4_ovf_sticky", DW'(overflow), DW'(1));
    swap = 1'b1; tick();
    chk("t4_active", DW'(active_count), DW'(PN - 1));
    chk("t4_ovf_clr", DW'(overflow), '0);
    chk("t4_bank_sel", DW'(bank_sel), DW'(1));
    chk("t4_shadow", DW'(shadow_count), '0);
    rd(8'd219, w(219)); tick();
    rd(1, w(1)); tick();
    rd(8'd220, '0); tick();
    rd(8'd255, '0); tick();
    rd(0, DW'(219)); tick();
    tick(); tick();

    // concurrent read of active bank and append stream to shadow bank
    for (int i = 0; i < 50; i++) begin
      wr_en = 1'b1; wr_data = x(i);
      rd(AW'(i + 1), w(i + 1));
      tick();
    end
    tick(); tick();
    chk("t5_shadow", DW'(shadow_count), DW'(50));
    chk("t5_active", DW'(active_count), DW'(219));

    // asynchronous reset with reads in flight
    rd(5, w(5)); tick();
    rd(6, w(6));
    #2;
    rst_n = 1'b0;
    #1;
    rd_en = 1'b0;
    flush_model();
    chk("t6_rd_valid", DW'(rd_valid), '0);
    chk("t6_rd_data", rd_data, '0);
    chk("t6_active", DW'(active_count), '0);
    chk("t6_shadow", DW'(shadow_count), '0);
    chk("t6_bank_sel", DW'(bank_sel), '0);
    chk("t6_overflow", DW'(overflow), '0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    rd(0, '0); tick();
    rd(1, '0); tick();
    tick(); tick();
    chk("t6_active_post", DW'(active_count), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pos_cell_pingpong.md
# pos_cell_pingpong

Double-buffered position memory for one cell. It is the parametrised successor to the single-port per-cell position RAM. Force evaluation reads the current-step positions from the active bank while motion update appends next-step positions into the shadow bank. A single swap pulse exchanges the two banks at the timestep boundary. It sits between the motion-update unit and the position cache, one instance per cell.

## Interface
Parameters:
- DATA_WIDTH, 96: particle word width, {posz, posy, posx}, 32 bits each.
- PARTICLE_NUM, 220: words per bank, including address 0.
- ADDR_WIDTH, 8: address width; must satisfy 2^ADDR_WIDTH >= PARTICLE_NUM.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request against the active bank.
- rd_addr  in  ADDR_WIDTH  read address; 0 = particle count, 1..count = particles.
- rd_data  out  DATA_WIDTH  read result.
- rd_valid  out  1  qualifies rd_data.
- wr_en  in  1  append one particle to the shadow bank.
- wr_data  in  DATA_WIDTH  particle word to append.
- swap  in  1  single-cycle pulse that exchanges the active and shadow banks.
- active_count  out  ADDR_WIDTH  particle count of the active bank.
- shadow_count  out  ADDR_WIDTH  particle count of the shadow bank.
- bank_sel  out  1  index of the active bank (0 or 1).
- overflow  out  1  sticky flag: an append was dropped because the shadow bank was full.

## Operation
- Storage: two RAMs, bank0 and bank1, each PARTICLE_NUM x DATA_WIDTH with a synchronous read.
  - Data words live at addresses 1..PARTICLE_NUM-1.
  - Counts are held in registers, not in RAM.
- Read path:
  - rd_addr == 0 returns {zeros, active_count}, zero-extended.
  - 1 <= rd_addr <= active_count returns the RAM word.
  - rd_addr > active_count returns all zeros (force-to-zero).
  - The bank, the count used for the range check, and the address class are all sampled in the issue cycle.
- Write path:
  - wr_en writes wr_data to shadow bank address shadow_count+1, then shadow_count increments.
  - Full condition: shadow_count == PARTICLE_NUM-1. An append while full is dropped, overflow sets, and the count holds.
- Swap (swap=1 at an edge):
  - bank_sel toggles.
  - active_count takes the old shadow_count, including any append accepted in the same cycle.
  - shadow_count clears to 0.
  - overflow clears unless a dropped append occurs in that same cycle.
- Simultaneous events:
  - wr_en with swap: the write lands in the old shadow bank, which becomes active, and it is counted in active_count.
  - rd_en with swap: the read is served from the old active bank with the old count.
  - The old active contents are not cleared; they are overwritten by later appends.
- Reset (asynchronous):
  - bank_sel=0, active_count=0, shadow_count=0, overflow=0.
  - rd_valid=0 and all in-flight reads are discarded.
  - rd_data=0.
  - RAM contents are not reset and are unreachable until rewritten, because both counts are 0.
- Initial load: append particles via the write port, then pulse swap.

## Timing
- Read latency is 2 cycles. rd_en at edge N gives rd_valid=1 with data at edge N+2, registered output.
- Fully pipelined: one read per cycle, and rd_valid follows the rd_en pattern delayed by 2.
- rd_data holds its last value when rd_valid=0.
- Writes commit at the edge where wr_en=1. shadow_count is visible 1 cycle later.
- A read of the new active bank issued the cycle after a swap returns the data written up to and including the swap cycle.
- Count outputs and bank_sel are registered and update at the same edge as the event.
- Reset assertion mid-read: that read's rd_valid never appears. Reset release: the first rd_en after release behaves normally.
- Reads and writes always target different banks, so there is no read-during-write hazard inside one bank.

## Test plan
- Reset, then rd_en at addr 0 -> 2 cycles later rd_valid=1, rd_data=0; active_count=0, bank_sel=0.
- Append 3 words A,B,C, swap, then read addrs 0,1,2,3,4 back-to-back -> after 2 cycles, 5 consecutive valids returning 3, A, B, C, 0; bank_sel=1, shadow_count=0.
- Append D on the same cycle as swap after A,B -> active_count=3, addr 3 reads D; a read issued in the swap cycle returns the old-bank data.
- Append PARTICLE_NUM words -> shadow_count=219, overflow=1, last word dropped; swap -> active_count=219, overflow=0; addr 219 reads word 219.
- Interleave a read stream of the active bank with an append stream each cycle for 50 cycles -> read data unchanged by the appends, and shadow_count=50.
- Assert rst_n low while 2 reads are in flight and counts are nonzero -> no rd_valid, all counts 0, bank_sel=0 immediately on reset assertion (asynchronous).
